// File: rtl/axi_sdcard_regs_if.sv
// AXI4-Lite control link between the SD-card master VIP and the register file.
interface axi_sdcard_regs_if #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 32
);
  logic [AddrWidth-1:0]   S_AXI_AWADDR;
  logic [2:0]             S_AXI_AWPROT;
  logic                   S_AXI_AWVALID;
  logic                   S_AXI_AWREADY;
  logic [DataWidth-1:0]   S_AXI_WDATA;
  logic [DataWidth/8-1:0] S_AXI_WSTRB;
  logic                   S_AXI_WVALID;
  logic                   S_AXI_WREADY;
  logic [1:0]             S_AXI_BRESP;
  logic                   S_AXI_BVALID;
  logic                   S_AXI_BREADY;
  logic [AddrWidth-1:0]   S_AXI_ARADDR;
  logic [2:0]             S_AXI_ARPROT;
  logic                   S_AXI_ARVALID;
  logic                   S_AXI_ARREADY;
  logic [DataWidth-1:0]   S_AXI_RDATA;
  logic [1:0]             S_AXI_RRESP;
  logic                   S_AXI_RVALID;
  logic                   S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_sdcard_regs.sv
// AXI4-Lite slave holding four 32-bit SD-card control registers with byte-strobed writes,
// registered read data and a per-register write pulse toward the SD-card core.
module axi_sdcard_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  axi_sdcard_regs_if.slave                s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [3:0]                      reg_wr_pulse
);
  localparam int unsigned NBytes = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RespOkay = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {WIdle, WHaveAw, WHaveW, WResp} wstate_e;
  typedef enum logic {RIdle, RData} rstate_e;

  // Anything above the 16-byte register window is out of range.
  function automatic logic in_range(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    return (a >> 4) == '0;
  endfunction

  logic                                    live_q;
  wstate_e                                 wstate_q, wstate_d;
  rstate_e                                 rstate_q, rstate_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0]           awaddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]           wdata_q;
  logic [NBytes-1:0]                       wstrb_q;
  logic [3:0][C_S_AXI_DATA_WIDTH-1:0]      regs_q, regs_d;
  logic [3:0]                              pulse_q, pulse_d;
  logic [1:0]                              bresp_q, bresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]           rdata_q, rdata_d;
  logic [1:0]                              rresp_q, rresp_d;

  logic                                    awready, wready, arready;
  logic                                    aw_hs, w_hs, ar_hs;
  logic                                    commit, c_ok, ar_ok;
  logic [C_S_AXI_ADDR_WIDTH-1:0]           c_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]           c_data;
  logic [NBytes-1:0]                       c_strb;
  logic [1:0]                              c_idx, ar_idx;
  logic                                    unused_prot;

  assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  // Readies are decoded purely from state flops, held low until the first edge out of reset.
  assign awready = live_q & ((wstate_q == WIdle) | (wstate_q == WHaveW));
  assign wready  = live_q & ((wstate_q == WIdle) | (wstate_q == WHaveAw));
  assign arready = live_q & (rstate_q == RIdle);

  assign aw_hs = s_axi.S_AXI_AWVALID & awready;
  assign w_hs  = s_axi.S_AXI_WVALID & wready;
  assign ar_hs = s_axi.S_AXI_ARVALID & arready;

  // The commit merges whichever half was latched earlier with the half arriving now.
  assign c_addr = (wstate_q == WHaveAw) ? awaddr_q : s_axi.S_AXI_AWADDR;
  assign c_data = (wstate_q == WHaveW) ? wdata_q : s_axi.S_AXI_WDATA;
  assign c_strb = (wstate_q == WHaveW) ? wstrb_q : s_axi.S_AXI_WSTRB;
  assign c_ok   = in_range(c_addr);
  assign c_idx  = c_addr[3:2];
  assign ar_ok  = in_range(s_axi.S_AXI_ARADDR);
  assign ar_idx = s_axi.S_AXI_ARADDR[3:2];

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_BVALID  = (wstate_q == WResp);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = (rstate_q == RData);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign reg_out             = regs_q;
  assign reg_wr_pulse        = pulse_q;

  // Out-of-reset gate: goes high on the first clock edge after ARESET falls.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // Write channel next-state and commit detection.
  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    case (wstate_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          wstate_d = WResp;
          commit   = 1'b1;
        end else if (aw_hs) begin
          wstate_d = WHaveAw;
        end else if (w_hs) begin
          wstate_d = WHaveW;
        end
      end
      WHaveAw: begin
        if (w_hs) begin
          wstate_d = WResp;
          commit   = 1'b1;
        end
      end
      WHaveW: begin
        if (aw_hs) begin
          wstate_d = WResp;
          commit   = 1'b1;
        end
      end
      WResp: begin
        if (s_axi.S_AXI_BREADY) wstate_d = WIdle;
      end
      default: wstate_d = WIdle;
    endcase
  end

  // Register update, write pulse and write response on commit.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = 4'b0000;
    bresp_d = bresp_q;
    if (commit) begin
      bresp_d = c_ok ? RespOkay : RespSlvErr;
      if (c_ok) begin
        pulse_d = 4'b0001 << c_idx;
        for (int b = 0; b < NBytes; b++) begin
          if (c_strb[b]) regs_d[c_idx][8*b +: 8] = c_data[8*b +: 8];
        end
      end
    end
  end

  // Read channel next-state; data is captured from the pre-commit register values.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      RIdle: begin
        if (ar_hs) begin
          rstate_d = RData;
          rdata_d  = ar_ok ? regs_q[ar_idx] : '0;
          rresp_d  = ar_ok ? RespOkay : RespSlvErr;
        end
      end
      RData: begin
        if (s_axi.S_AXI_RREADY) rstate_d = RIdle;
      end
      default: rstate_d = RIdle;
    endcase
  end

  // State, register file and response flops; reset discards any half-accepted write.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q <= WIdle;
      rstate_q <= RIdle;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      regs_q   <= '0;
      pulse_q  <= 4'b0000;
      bresp_q  <= RespOkay;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      regs_q   <= regs_d;
      pulse_q  <= pulse_d;
      bresp_q  <= bresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      if (aw_hs) awaddr_q <= s_axi.S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
    end
  end
endmodule

// File: tb/tb_axi_sdcard_regs.sv
// Randomized bench for axi_sdcard_regs against a simple array model of the four registers.
module tb_axi_sdcard_regs;
  localparam int unsigned AW = 8;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;

  axi_sdcard_regs_if #(.AddrWidth(AW), .DataWidth(32)) bus ();

  axi_sdcard_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .s_axi       (bus.slave),
    .reg_out     (reg_out),
    .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model [4];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] model_out();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One write with independent AW/W start delays and BREADY held low for b_dly cycles.
  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, input string tag);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0;
    bit ok = (addr[7:4] == 4'h0);
    int idx = int'(addr[3:2]);
    while (!(aw_done && w_done)) begin
      @(negedge ACLK);
      check_eq({tag, " bvalid early"}, bus.S_AXI_BVALID, 0);
      bus.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge ACLK);
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
      cyc++;
      if (cyc > 50) begin
        check_eq({tag, " write handshake timeout"}, 1, 0);
        bus.S_AXI_AWVALID = 0;
        bus.S_AXI_WVALID  = 0;
        return;
      end
    end
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WVALID  = 0;
    if (ok) model[idx] = merge(model[idx], data, strb);
    check_eq({tag, " bvalid"}, bus.S_AXI_BVALID, 1);
    check_eq({tag, " bresp"}, bus.S_AXI_BRESP, ok ? 2'b00 : 2'b10);
    check_eq({tag, " pulse"}, reg_wr_pulse, ok ? (4'b0001 << idx) : 4'b0000);
    check_eq({tag, " reg_out"}, reg_out, model_out());
    for (int i = 0; i < b_dly; i++) begin
      @(negedge ACLK);
      check_eq({tag, " bvalid hold"}, bus.S_AXI_BVALID, 1);
      check_eq({tag, " bresp hold"}, bus.S_AXI_BRESP, ok ? 2'b00 : 2'b10);
      check_eq({tag, " pulse once"}, reg_wr_pulse, 0);
      check_eq({tag, " no new aw/w"}, {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 0);
    end
    bus.S_AXI_BREADY = 1;
    @(negedge ACLK);
    bus.S_AXI_BREADY = 0;
    check_eq({tag, " bvalid drop"}, bus.S_AXI_BVALID, 0);
    check_eq({tag, " pulse clear"}, reg_wr_pulse, 0);
  endtask

  // One read with RREADY held low for r_dly cycles; expectation comes from the model.
  task automatic do_read(input logic [AW-1:0] addr, input int r_dly, input string tag);
    bit ok = (addr[7:4] == 4'h0);
    logic [31:0] exp = ok ? model[int'(addr[3:2])] : 32'h0;
    int cyc = 0;
    @(negedge ACLK);
    bus.S_AXI_ARVALID = 1;
    bus.S_AXI_ARADDR  = addr;
    while (!bus.S_AXI_ARREADY) begin
      @(negedge ACLK);
      cyc++;
      if (cyc > 50) begin
        check_eq({tag, " arready timeout"}, 1, 0);
        bus.S_AXI_ARVALID = 0;
        return;
      end
    end
    @(negedge ACLK);
    bus.S_AXI_ARVALID = 0;
    check_eq({tag, " rvalid"}, bus.S_AXI_RVALID, 1);
    check_eq({tag, " rdata"}, bus.S_AXI_RDATA, exp);
    check_eq({tag, " rresp"}, bus.S_AXI_RRESP, ok ? 2'b00 : 2'b10);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge ACLK);
      check_eq({tag, " rvalid hold"}, bus.S_AXI_RVALID, 1);
      check_eq({tag, " rdata hold"}, bus.S_AXI_RDATA, exp);
      check_eq({tag, " no new ar"}, bus.S_AXI_ARREADY, 0);
    end
    bus.S_AXI_RREADY = 1;
    @(negedge ACLK);
    bus.S_AXI_RREADY = 0;
    check_eq({tag, " rvalid drop"}, bus.S_AXI_RVALID, 0);
  endtask

  initial begin
    logic [31:0] old_v, new_v;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 0;
    bus.S_AXI_BREADY = 0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_RREADY = 0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;

    // Reset release
    #100;
    check_eq("rst readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 0);
    check_eq("rst valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 0);
    check_eq("rst resp/data", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, 0);
    check_eq("rst reg_out", reg_out, 0);
    check_eq("rst pulse", reg_wr_pulse, 0);
    #100;
    ARESET = 0;
    #1;
    check_eq("post-release readies low", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
             bus.S_AXI_ARREADY}, 0);
    @(negedge ACLK);
    check_eq("live readies high", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
             bus.S_AXI_ARREADY}, 3'b111);

    // Sequential write/readback
    for (int i = 0; i < 4; i++) do_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, "seq wr");
    for (int i = 0; i < 4; i++) do_read(AW'(4 * i), 0, "seq rd");

    // Byte strobes
    do_write(8'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0, "strb full");
    do_write(8'h04, 32'h11223344, 4'b0101, 0, 0, 0, "strb part");
    check_eq("strb reg1 value", reg_out[63:32], 32'hAA22CC44);
    do_read(8'h04, 0, "strb rd");

    // AW/W ordering and zero strobes
    do_write(8'h08, 32'h0BADF00D, 4'hF, 3, 0, 0, "w first");
    do_write(8'h08, 32'h12345678, 4'hF, 0, 3, 0, "aw first");
    do_write(8'h00, 32'hFFFFFFFF, 4'h0, 0, 0, 0, "strb zero");

    // Backpressure
    do_write(8'h0C, 32'hCAFEBABE, 4'hF, 0, 0, 5, "bp wr");
    do_read(8'h0C, 5, "bp rd");

    // Out of range
    do_write(8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 1, "oor wr");
    do_read(8'h10, 1, "oor rd");

    // Same-cycle read and write commit to reg2: read sees the old value
    old_v = model[2];
    new_v = 32'h5A5A0F0F;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 1; bus.S_AXI_AWADDR = 8'h08;
    bus.S_AXI_WVALID = 1;  bus.S_AXI_WDATA = new_v; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARVALID = 1; bus.S_AXI_ARADDR = 8'h08;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_ARVALID = 0;
    model[2] = new_v;
    check_eq("same-cycle rdata old", bus.S_AXI_RDATA, old_v);
    check_eq("same-cycle valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b11);
    check_eq("same-cycle reg_out", reg_out, model_out());
    bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
    @(negedge ACLK);
    bus.S_AXI_BREADY = 0; bus.S_AXI_RREADY = 0;
    check_eq("same-cycle drop", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 0);

    // Reset with a latched AW pending: the AW must be forgotten
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 1; bus.S_AXI_AWADDR = 8'h04;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 0;
    ARESET = 1;
    #1;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    check_eq("midrst reg_out", reg_out, 0);
    check_eq("midrst outs", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 0);
    @(negedge ACLK);
    ARESET = 0;
    @(negedge ACLK);
    bus.S_AXI_WVALID = 1; bus.S_AXI_WDATA = 32'h600DD00D; bus.S_AXI_WSTRB = 4'hF;
    @(negedge ACLK);
    bus.S_AXI_WVALID = 0;
    check_eq("midrst aw discarded", bus.S_AXI_BVALID, 0);
    @(negedge ACLK);
    check_eq("midrst still no resp", bus.S_AXI_BVALID, 0);
    bus.S_AXI_AWVALID = 1; bus.S_AXI_AWADDR = 8'h00;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 0;
    model[0] = 32'h600DD00D;
    check_eq("midrst late aw bvalid", bus.S_AXI_BVALID, 1);
    check_eq("midrst late aw reg_out", reg_out, model_out());
    check_eq("midrst late aw pulse", reg_wr_pulse, 4'b0001);
    bus.S_AXI_BREADY = 1;
    @(negedge ACLK);
    bus.S_AXI_BREADY = 0;

    // Randomized mix
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom_range(0, 21)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "rnd wr");
      else
        do_read(AW'($urandom_range(0, 21)), $urandom_range(0, 2), "rnd rd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_sdcard_regs.md
# axi_sdcard_regs

AXI4-Lite slave register file: the responder end of the control link the SD-card master VIP drives. It holds four 32-bit control/data registers at byte offsets 0x0, 0x4, 0x8 and 0xC. It accepts single-beat writes with byte strobes and returns stored values on reads. It exposes the register contents and per-register write strobes to the SD-card core logic.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; must be ≥ 4.

Ports:
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response: OKAY = 00, SLVERR = 10.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- reg_out  out  128  register contents; reg_out[32k+31:32k] holds register k.
- reg_wr_pulse  out  4  one-cycle pulse per register on each committed write.

## Operation
- Address decode:
  - register index = ADDR[3:2].
  - If C_S_AXI_ADDR_WIDTH > 4 and ADDR[C_S_AXI_ADDR_WIDTH-1:4] is nonzero, the access is out of range.
  - ADDR[1:0] is ignored.
- In-reset gate: an internal flop `live` resets to 0 and sets to 1 on the first ACLK edge after ARESET falls. All READY outputs are forced to 0 while `live` = 0.
- Write FSM has four states:
  - W_IDLE: AWREADY = WREADY = 1.
  - W_HAVE_AW: AWREADY = 0, WREADY = 1.
  - W_HAVE_W: AWREADY = 1, WREADY = 0.
  - W_RESP: both readies 0, BVALID = 1.
- Write FSM transitions:
  - W_IDLE → W_RESP when AW and W handshake in the same cycle.
  - W_IDLE → W_HAVE_AW on an AW-only handshake; the address is latched.
  - W_IDLE → W_HAVE_W on a W-only handshake; data and strobes are latched.
  - W_HAVE_AW / W_HAVE_W → W_RESP on the missing handshake.
  - W_RESP → W_IDLE when BREADY = 1.
- Commit: on the edge entering W_RESP:
  - In range: each byte b of the target register with WSTRB[b] = 1 is updated, reg_wr_pulse[idx] pulses for that one cycle, and BRESP = OKAY.
  - Out of range: no register changes, no pulse, BRESP = SLVERR.
  - WSTRB = 0000 in range: register unchanged, pulse still fires, BRESP = OKAY.
- Only one write is outstanding at a time; no new AW or W is accepted until the B handshake completes.
- Read FSM has two states:
  - R_IDLE: ARREADY = 1.
  - R_DATA: ARREADY = 0, RVALID = 1.
- Read FSM transitions:
  - On an AR handshake in R_IDLE, RDATA and RRESP are registered and the FSM goes to R_DATA.
  - In range: RDATA = register value, RRESP = OKAY.
  - Out of range: RDATA = 0, RRESP = SLVERR.
  - R_DATA → R_IDLE when RREADY = 1.
- Reads and writes are fully independent and may complete in the same cycle.

## Timing
- Reset values: all registers 0; reg_out 0; reg_wr_pulse 0; BVALID 0; RVALID 0; BRESP / RRESP 00; RDATA 0; all READY outputs 0. Both FSMs reset to their IDLE states.
- All outputs come from flops or are decoded from state flops; there is no combinational path from any input to any output.
- Write latency: BVALID is 1 on the cycle after the second of AW/W handshakes. reg_out shows the new value in that same cycle.
- Read latency: RVALID is 1 on the cycle after the AR handshake.
- Minimum repeat interval is 2 cycles per transaction per channel when BREADY/RREADY are held high.
- BVALID, BRESP, RVALID, RDATA and RRESP stay stable until their handshake.
- Same-cycle AR handshake and write commit to the same register: RDATA returns the pre-write value.
- ARESET asserted mid-transaction:
  - Takes effect immediately.
  - Pending latched AW/W state is discarded and registers clear.
  - No response is issued for the aborted transaction.
- AW or W presented before `live` = 1 is not accepted.

## Test plan
- Reset release: ARESET high for 200 ns then low → all READY outputs are 0 until the first edge after release and 1 after it. All outputs are 0 during reset.
- Sequential write/readback:
  - Stimulus: write 0x1, 0x2, 0x3, 0x4 to offsets 0x0 to 0xC, then read the four offsets back.
  - Required: every read returns the written value with RRESP = OKAY. Every write gives BRESP = OKAY and a single pulse on the correct reg_wr_pulse bit.
- Byte strobes: reg1 = 0xAABBCCDD, then write 0x11223344 with WSTRB = 0101 → reading reg1 returns 0xAA22CC44.
- AW/W ordering:
  - W presented 3 cycles before AW → BVALID rises 1 cycle after the AW handshake.
  - The reverse order (AW first) gives the same result.
  - Simultaneous AW and W gives BVALID on the next cycle.
- Backpressure: BREADY and RREADY held low 5 cycles → BVALID/RVALID and their data stay stable. No new AW/AR is accepted until the handshake completes.
- Out of range, with C_S_AXI_ADDR_WIDTH = 8:
  - A write to 0x10 → SLVERR, no register change, no pulse.
  - A read from 0x10 → RDATA = 0, RRESP = SLVERR.
